// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides. MUL runs as a
// radix-2 shift-add over WIDTH cycles; every other op completes in one cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             cout,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] WIDTH_B = WIDTH[WIDTH-1:0];

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   y_q, y_d, y_hi_q, y_hi_d;
    logic               cout_q, cout_d, bout_q, bout_d;
    logic               zero_q, zero_d, ovf_q, ovf_d;

    logic [WIDTH:0]     add_full, sub_full, mul_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_cout, alu_bout, alu_ovf, shift_ok;

    // Single-cycle datapath, evaluated straight from the operand bus at accept.
    always_comb begin
        add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        shift_ok = (b < WIDTH_B);
        alu_y    = '0;
        alu_cout = 1'b0;
        alu_bout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_ADD: begin
                alu_y    = add_full[WIDTH-1:0];
                alu_cout = add_full[WIDTH];
                alu_ovf  = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_y    = sub_full[WIDTH-1:0];
                alu_bout = sub_full[WIDTH];
                alu_ovf  = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
            end
            OP_SHL:  alu_y = shift_ok ? (a << b) : '0;
            OP_SHR:  alu_y = shift_ok ? (a >> b) : '0;
            default: alu_y = '0;
        endcase
    end

    // Shift-add step: the low half starts as the multiplier and shifts out
    // one bit per cycle while partial sums accumulate into the high half.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        cout_d  = cout_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        mcand_d = a;
                        prod_d  = {{WIDTH{1'b0}}, b};
                    end else begin
                        state_d = DONE;
                        y_d     = alu_y;
                        y_hi_d  = '0;
                        cout_d  = alu_cout;
                        bout_d  = alu_bout;
                        ovf_d   = alu_ovf;
                        zero_d  = (alu_y == '0);
                    end
                end
            end
            BUSY: begin
                prod_d = prod_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    y_d     = prod_next[WIDTH-1:0];
                    y_hi_d  = prod_next[2*WIDTH-1:WIDTH];
                    cout_d  = 1'b0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = (prod_next == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            y_q     <= '0;
            y_hi_q  <= '0;
            cout_q  <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            cout_q  <= cout_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign cout      = cout_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed corner cases plus random transactions,
// each compared against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready;
    logic         cout, bout, zero, ovf;
    logic [W-1:0] a, b, y, y_hi;
    logic [2:0]   op;

    int vectors     = 0;
    int miscompares = 0;
    int exp_y, exp_hi, exp_cout, exp_bout, exp_zero, exp_ovf;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .cout(cout), .bout(bout), .zero(zero), .ovf(ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected results from plain integer arithmetic on the operand values.
    task automatic referenceModel(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
        int full, half, ia, ib, ic, sa, sb, s, ss, r;
        full = 1 << W;
        half = full / 2;
        ia = int'(aa);
        ib = int'(bb);
        ic = c ? 1 : 0;
        sa = (ia >= half) ? ia - full : ia;
        sb = (ib >= half) ? ib - full : ib;
        exp_hi = 0; exp_cout = 0; exp_bout = 0; exp_ovf = 0; r = 0;
        case (o)
            OP_AND: r = ia & ib;
            OP_OR:  r = ia | ib;
            OP_XOR: r = ia ^ ib;
            OP_ADD: begin
                s  = ia + ib + ic;
                ss = sa + sb + ic;
                r  = s % full;
                exp_cout = (s >= full) ? 1 : 0;
                exp_ovf  = (ss >= half || ss < -half) ? 1 : 0;
            end
            OP_SUB: begin
                s  = ia - ib - ic;
                ss = sa - sb - ic;
                r  = (s + 2 * full) % full;
                exp_bout = (s < 0) ? 1 : 0;
                exp_ovf  = (ss >= half || ss < -half) ? 1 : 0;
            end
            OP_MUL: begin
                s = ia * ib;
                r = s % full;
                exp_hi = s / full;
            end
            OP_SHL: r = (ib >= W) ? 0 : (ia * (1 << ib)) % full;
            default: r = (ib >= W) ? 0 : ia / (1 << ib);
        endcase
        exp_y    = r;
        exp_zero = (r == 0 && exp_hi == 0) ? 1 : 0;
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, "_y"},    32'(y),    exp_y);
        checkOutput({tag, "_y_hi"}, 32'(y_hi), exp_hi);
        checkOutput({tag, "_cout"}, 32'(cout), exp_cout);
        checkOutput({tag, "_bout"}, 32'(bout), exp_bout);
        checkOutput({tag, "_zero"}, 32'(zero), exp_zero);
        checkOutput({tag, "_ovf"},  32'(ovf),  exp_ovf);
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic c, input int stall);
        int lat;
        referenceModel(o, aa, bb, c);
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1; op = o; a = aa; b = bb; cin = c; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom); cin = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            checkOutput("in_ready_busy", 32'(in_ready), 0);
        end while (out_valid !== 1'b1 && lat < 4 * W);
        checkOutput("latency", lat, (o == OP_MUL) ? W + 1 : 1);
        checkResult("done");
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 3'($urandom); cin = 1'($urandom);
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(in_ready), 0);
            checkOutput("stall_out_valid", 32'(out_valid), 1);
            checkResult("stall");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("handoff_in_ready", 32'(in_ready), 1);
        checkOutput("handoff_out_valid", 32'(out_valid), 0);
        checkOutput("held_y", 32'(y), exp_y);
        checkOutput("held_y_hi", 32'(y_hi), exp_hi);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 8'h12; b = 8'h34; cin = 1'b0; op = OP_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        exp_y = 0; exp_hi = 0; exp_cout = 0; exp_bout = 0; exp_zero = 0; exp_ovf = 0;
        checkResult("rst");

        applyStimulus(OP_ADD, 8'h7F, 8'h01, 1'b0, 0);
        applyStimulus(OP_ADD, 8'hFF, 8'h00, 1'b1, 0);
        applyStimulus(OP_SUB, 8'h05, 8'h05, 1'b1, 0);
        applyStimulus(OP_SUB, 8'h80, 8'h01, 1'b0, 0);
        applyStimulus(OP_AND, 8'hF0, 8'h3C, 1'b0, 0);
        applyStimulus(OP_SUB, 8'h00, 8'h01, 1'b0, 0);
        applyStimulus(OP_MUL, 8'hFF, 8'hFF, 1'b0, 0);
        applyStimulus(OP_MUL, 8'h00, 8'h37, 1'b1, 5);
        applyStimulus(OP_ADD, 8'h3C, 8'h4B, 1'b1, 5);
        applyStimulus(OP_SHL, 8'h81, 8'h01, 1'b0, 0);
        applyStimulus(OP_SHR, 8'h81, 8'h09, 1'b0, 0);

        // Abort a multiply with reset in its fourth busy cycle.
        @(negedge clk);
        in_valid = 1'b1; op = OP_MUL; a = 8'hFF; b = 8'hFF; cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            checkOutput("abort_out_valid", 32'(out_valid), 0);
            checkOutput("abort_in_ready", 32'(in_ready), 1);
            @(negedge clk);
        end
        checkOutput("abort_y", 32'(y), 0);
        checkOutput("abort_y_hi", 32'(y_hi), 0);
        applyStimulus(OP_ADD, 8'h01, 8'h02, 1'b0, 0);

        for (int n = 0; n < 80; n++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom);
            ra = W'($urandom);
            rb = (ro == OP_SHL || ro == OP_SHR) ? W'($urandom_range(0, W + 2)) : W'($urandom);
            applyStimulus(ro, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Performs AND/OR/XOR/ADD/SUB/SHL/SHR in one cycle, and unsigned multiply as a multi-cycle shift-add operation.
- Uses valid/ready handshakes on both the operand and result sides, so it can sit between a sequencer/register file and a writeback stage.
- Flags are defined for every opcode; no output holds a stale value from a previous operation.

Parameters:
- WIDTH, 8, operand/result width; must be a power of 2 and at least 4.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept an operand bundle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for ADD, borrow-in for SUB.
- op  input  3  opcode: 000 AND, 001 OR, 010 SUB, 011 ADD, 100 XOR, 101 MUL, 110 SHL, 111 SHR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result; low half of the product for MUL.
- y_hi  output  WIDTH  high half of the product for MUL; 0 for all other ops.
- cout  output  1  carry-out; ADD only, 0 otherwise.
- bout  output  1  borrow-out; SUB only, 0 otherwise.
- zero  output  1  result is zero; for MUL this is the full 2*WIDTH product.
- ovf  output  1  signed overflow; ADD/SUB only, 0 otherwise.

Behaviour:
- Reset: when rst=1 at a clock edge, go to IDLE and clear in_ready-gating state. Next cycle: out_valid=0, y=0, y_hi=0, all flags 0, in_ready=1.
- Reset mid-operation: a reset in BUSY or DONE aborts the operation and discards the result. in_ready=1 the cycle after reset deasserts.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: a transfer occurs when in_valid&&in_ready at a clock edge. a, b, cin and op are captured into internal registers then; later changes to the inputs are ignored.
- IDLE -> DONE on accept of a single-cycle op. The result and flags are registered at that edge, so out_valid=1 the next cycle (latency 1).
- IDLE -> BUSY on accept of MUL:
  - Radix-2 shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY.
  - Iteration counter runs 0..WIDTH-1, then BUSY -> DONE.
  - out_valid rises WIDTH+1 cycles after the accept edge.
- DONE -> IDLE on out_valid&&out_ready. in_ready returns to 1 the following cycle.
- Maximum throughput is one single-cycle op per 2 cycles; no accept is taken in the cycle of result handoff.
- Output stability: y, y_hi and the flags hold stable for the whole of DONE regardless of out_ready. They keep their values after handoff until the next result is written.
- Arithmetic:
  - ADD: {cout,y} = a + b + cin (WIDTH+1-bit). ovf = (a[MSB]==b[MSB]) && (y[MSB]!=a[MSB]).
  - SUB: y = a - b - cin modulo 2^WIDTH. bout = 1 iff a < b + cin, unsigned and evaluated at WIDTH+1 bits. ovf = (a[MSB]!=b[MSB]) && (y[MSB]!=a[MSB]).
  - AND/OR/XOR: bitwise.
  - SHL/SHR: logical shift of a by the unsigned value of b, zero fill. If b >= WIDTH, y = 0.
  - MUL: {y_hi,y} = a*b, unsigned; cin is ignored.
  - zero = (y==0) for non-MUL ops; for MUL, zero = ({y_hi,y}==0).
- Flag scope: cout, bout and ovf are 0 for every opcode to which they do not apply. y_hi is 0 for all non-MUL ops.
- Simultaneous events:
  - in_valid asserted while BUSY/DONE: not accepted; the caller must hold in_valid.
  - rst together with in_valid or out_ready: reset wins.
- Wrap-around: ADD of all-ones + 1 gives y = 0, cout = 1, zero = 1. SUB of 0 - 1 gives y = all-ones, bout = 1.

Test Plan (WIDTH=8):
- Reset: assert rst for 2 cycles while in_valid=1 -> out_valid=0, y=0, y_hi=0, all flags 0, in_ready=1 after release.
- ADD:
  - a=0x7F, b=0x01, cin=0 -> one cycle later y=0x80, ovf=1, cout=0, zero=0.
  - a=0xFF, b=0x00, cin=1 -> y=0x00, cout=1, zero=1, ovf=0.
- SUB:
  - a=0x05, b=0x05, cin=1 -> y=0xFF, bout=1, zero=0.
  - a=0x80, b=0x01, cin=0 -> y=0x7F, ovf=1, bout=0. Then issue AND -> bout=0, ovf=0.
- MUL latency: a=0xFF, b=0xFF -> in_ready=0 for 9 cycles; out_valid rises on cycle 9 after accept with y_hi=0xFE, y=0x01, zero=0. Also a=0x00, b=0x37 -> zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling a, b, op -> y and flags unchanged, in_ready=0. Raise out_ready -> in_ready=1 next cycle.
- Shift and abort:
  - SHL a=0x81, b=1 -> y=0x02.
  - SHR a=0x81, b=9 -> y=0x00, zero=1.
  - Start MUL, assert rst on the 4th BUSY cycle -> no out_valid; the next ADD 0x01+0x02 returns y=0x03.
